// File: rtl/hart_sched.sv
// Barrel-thread issue scheduler: round-robin picks one runnable hart per cycle and
// tracks each issued instruction down a fixed-depth pipeline as one-hot hart selects.
module hart_sched #(
  parameter int unsigned NUM_HART  = 4,
  parameter int unsigned NUM_STAGE = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_HART-1:0]           hart_en,
  input  logic [NUM_HART-1:0]           hart_stall,
  input  logic                          flush_en,
  input  logic [NUM_HART-1:0]           flush_hart_sel,
  output logic [NUM_STAGE-1:0]          stage_valid,
  output logic [NUM_STAGE*NUM_HART-1:0] stage_hart_sel,
  output logic [NUM_HART-1:0]           hart_busy,
  output logic [31:0]                   issue_count
);

  localparam int unsigned PtrW = (NUM_HART > 1) ? $clog2(NUM_HART) : 1;

  logic [NUM_STAGE-1:0] valid_q;
  logic [NUM_HART-1:0]  sel_q [NUM_STAGE];
  logic [PtrW-1:0]      ptr_q;
  logic [31:0]          count_q;

  logic [NUM_HART-1:0]  blocked;
  logic [NUM_HART-1:0]  flush_mask;
  logic [NUM_HART-1:0]  eligible;
  logic [NUM_STAGE-2:0] keep;
  logic                 grant_vld;
  logic [PtrW-1:0]      grant_idx;
  logic [NUM_HART-1:0]  grant_oh;

  // The last stage is excluded so a lone hart can re-issue every NUM_STAGE cycles.
  always_comb begin
    blocked    = '0;
    flush_mask = flush_en ? flush_hart_sel : '0;
    for (int unsigned k = 0; k < NUM_STAGE - 1; k++) begin
      if (valid_q[k]) blocked = blocked | sel_q[k];
      keep[k] = valid_q[k] & ~(|(sel_q[k] & flush_mask));
    end
    eligible = hart_en & ~hart_stall & ~blocked & ~flush_mask;
  end

  always_comb begin : arb
    int unsigned idx;
    grant_vld = 1'b0;
    grant_idx = ptr_q;
    grant_oh  = '0;
    idx       = 0;
    for (int unsigned j = 1; j <= NUM_HART; j++) begin
      idx = (32'(ptr_q) + j) % NUM_HART;
      if (!grant_vld && eligible[PtrW'(idx)]) begin
        grant_vld = 1'b1;
        grant_idx = PtrW'(idx);
      end
    end
    if (grant_vld) grant_oh[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int unsigned k = 0; k < NUM_STAGE; k++) sel_q[k] <= '0;
      ptr_q   <= PtrW'(NUM_HART - 1);
      count_q <= '0;
    end else begin
      valid_q[0] <= grant_vld;
      sel_q[0]   <= grant_oh;
      for (int unsigned k = 1; k < NUM_STAGE; k++) begin
        valid_q[k] <= keep[k-1];
        sel_q[k]   <= keep[k-1] ? sel_q[k-1] : '0;
      end
      if (grant_vld) begin
        ptr_q   <= grant_idx;
        count_q <= count_q + 32'd1;
      end
    end
  end

  always_comb begin
    hart_busy = '0;
    for (int unsigned k = 0; k < NUM_STAGE; k++) begin
      stage_hart_sel[k*NUM_HART +: NUM_HART] = sel_q[k];
      if (valid_q[k]) hart_busy = hart_busy | sel_q[k];
    end
  end

  assign stage_valid = valid_q;
  assign issue_count = count_q;

endmodule

// File: tb/tb_hart_sched.sv
// Directed and randomized checks of hart_sched against a hart-id-per-stage model.
module tb_hart_sched;

  localparam int NH = 4;
  localparam int NS = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [NH-1:0]    hart_en, hart_stall, flush_hart_sel;
  logic             flush_en;
  logic [NS-1:0]    stage_valid;
  logic [NS*NH-1:0] stage_hart_sel;
  logic [NH-1:0]    hart_busy;
  logic [31:0]      issue_count;

  hart_sched #(.NUM_HART(NH), .NUM_STAGE(NS)) dut (
    .clk            (clk),
    .rst            (rst),
    .hart_en        (hart_en),
    .hart_stall     (hart_stall),
    .flush_en       (flush_en),
    .flush_hart_sel (flush_hart_sel),
    .stage_valid    (stage_valid),
    .stage_hart_sel (stage_hart_sel),
    .hart_busy      (hart_busy),
    .issue_count    (issue_count)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  // Reference model: hart id held in each stage (-1 = empty), last granted hart, count.
  int          st [NS];
  int          ptr;
  int unsigned cnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int k = 0; k < NS; k++) st[k] = -1;
    ptr = NH - 1;
    cnt = 0;
  endtask

  task automatic model_step();
    bit busy_early [NH];
    int grant;
    for (int h = 0; h < NH; h++) busy_early[h] = 0;
    for (int k = 0; k < NS - 1; k++) if (st[k] >= 0) busy_early[st[k]] = 1;
    grant = -1;
    for (int j = 1; j <= NH; j++) begin
      int h;
      h = (ptr + j) % NH;
      if (grant < 0 && hart_en[h] && !hart_stall[h] && !busy_early[h]
          && !(flush_en && flush_hart_sel[h])) grant = h;
    end
    for (int k = NS - 1; k >= 1; k--) begin
      st[k] = st[k-1];
      if (st[k] >= 0 && flush_en && flush_hart_sel[st[k]]) st[k] = -1;
    end
    st[0] = grant;
    if (grant >= 0) begin
      ptr = grant;
      cnt++;
    end
  endtask

  function automatic logic [NS-1:0] exp_valid();
    logic [NS-1:0] v = '0;
    for (int k = 0; k < NS; k++) v[k] = (st[k] >= 0);
    return v;
  endfunction

  function automatic logic [NS*NH-1:0] exp_sel();
    logic [NS*NH-1:0] s = '0;
    for (int k = 0; k < NS; k++) if (st[k] >= 0) s[k*NH + st[k]] = 1'b1;
    return s;
  endfunction

  function automatic logic [NH-1:0] exp_busy();
    logic [NH-1:0] b = '0;
    for (int k = 0; k < NS; k++) if (st[k] >= 0) b[st[k]] = 1'b1;
    return b;
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".valid"}, 64'(stage_valid), 64'(exp_valid()));
    check({tag, ".sel"},   64'(stage_hart_sel), 64'(exp_sel()));
    check({tag, ".busy"},  64'(hart_busy), 64'(exp_busy()));
    check({tag, ".count"}, 64'(issue_count), 64'(cnt));
  endtask

  // Inputs are set #1 after an edge; the model advances and outputs are sampled #1 after the next.
  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [NH-1:0] exp_rr;
    bit found;
    rst = 1'b1;
    hart_en = '0; hart_stall = '0; flush_en = 1'b0; flush_hart_sel = '0;
    model_reset();
    @(posedge clk); #1;
    check_all("reset");
    rst = 1'b0;

    // All harts enabled: strict rotation starting at hart 0.
    hart_en = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      cycle("rr_all");
      exp_rr = 4'b0001 << (i % 4);
      check("rr_all.stage0", 64'(stage_hart_sel[NH-1:0]), 64'(exp_rr));
    end
    check("rr_all.count8", 64'(issue_count), 64'd8);

    // Single hart: one issue every NS cycles.
    hart_en = 4'b0100;
    for (int i = 0; i < 12; i++) cycle("single");
    check("single.busy", 64'(hart_busy), 64'(4'b0100));

    // Stalled hart 1 is skipped, then rejoins.
    hart_en = 4'b1111; hart_stall = 4'b0010;
    for (int i = 0; i < 12; i++) cycle("stall");
    hart_stall = '0;
    for (int i = 0; i < 8; i++) cycle("unstall");

    // Flush hart 2 while it sits in stage 1.
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      if (st[1] == 2) found = 1;
      else cycle("seek_flush");
    end
    check("flush.found", 64'(found), 64'd1);
    flush_en = 1'b1; flush_hart_sel = 4'b0100;
    cycle("flush");
    check("flush.stage2", 64'(stage_valid[2]), 64'd0);
    check("flush.busy2", 64'(hart_busy[2]), 64'd0);
    flush_en = 1'b0;
    for (int i = 0; i < 6; i++) cycle("post_flush");

    // Drop hart_en[0] while hart 0 is in stage 0: it still drains.
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      if (st[0] == 0) found = 1;
      else cycle("seek_dis");
    end
    check("dis.found", 64'(found), 64'd1);
    hart_en = 4'b1110;
    for (int i = 0; i < 8; i++) cycle("dis");

    // Random traffic including overlapping and multi-hot flushes.
    for (int i = 0; i < 400; i++) begin
      hart_en        = 4'($urandom_range(0, 15));
      hart_stall     = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
      flush_en       = ($urandom_range(0, 4) == 0);
      flush_hart_sel = 4'($urandom_range(0, 15));
      cycle("rand");
    end

    // Asynchronous reset between edges, then first grant is hart 0.
    hart_en = 4'b1111; hart_stall = '0; flush_en = 1'b0;
    for (int i = 0; i < 3; i++) cycle("pre_arst");
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check("arst.valid", 64'(stage_valid), 64'd0);
    check("arst.busy", 64'(hart_busy), 64'd0);
    check("arst.count", 64'(issue_count), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    cycle("post_arst");
    check("post_arst.stage0", 64'(stage_hart_sel[NH-1:0]), 64'(4'b0001));
    for (int i = 0; i < 4; i++) cycle("post_arst_run");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
